// File: rtl/thunderbird_turn_signal_if.sv
// ============================================================================
// Module   : thunderbird_turn_signal_if
// Purpose  : Switch inputs and lamp outputs of the turn-signal sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface thunderbird_turn_signal_if;
  logic left_sw;
  logic right_sw;
  logic la;
  logic lb;
  logic lc;
  logic ra;
  logic rb;
  logic rc;

  // Master drives the switches and observes the lamps
  modport master (
    output left_sw,
    output right_sw,
    input  la,
    input  lb,
    input  lc,
    input  ra,
    input  rb,
    input  rc
  );

  modport slave (
    input  left_sw,
    input  right_sw,
    output la,
    output lb,
    output lc,
    output ra,
    output rb,
    output rc
  );
endinterface

`default_nettype wire

// File: rtl/thunderbird_turn_signal.sv
// ============================================================================
// Module   : thunderbird_turn_signal
// Purpose  : Moore FSM sequencing Thunderbird-style left/right sweeps and hazard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module thunderbird_turn_signal (
  input  wire logic                      clk,
  input  wire logic                      reset,
  thunderbird_turn_signal_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] lamps;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sweeps run to completion; switches are only looked at from IDLE
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        case ({bus.left_sw, bus.right_sw})
          2'b10:   state_d = L1;
          2'b01:   state_d = R1;
          2'b11:   state_d = HAZ;
          default: state_d = IDLE;
        endcase
      end
      L1:      state_d = L2;
      L2:      state_d = L3;
      L3:      state_d = IDLE;
      R1:      state_d = R2;
      R2:      state_d = R3;
      R3:      state_d = IDLE;
      HAZ:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lamp vector {la,lb,lc,ra,rb,rc}, decoded purely from state
  always_comb begin
    lamps = 6'b000000;
    case (state_q)
      L1:      lamps = 6'b100000;
      L2:      lamps = 6'b110000;
      L3:      lamps = 6'b111000;
      R1:      lamps = 6'b000100;
      R2:      lamps = 6'b000110;
      R3:      lamps = 6'b000111;
      HAZ:     lamps = 6'b111111;
      default: lamps = 6'b000000;
    endcase
  end

  assign bus.la = lamps[5];
  assign bus.lb = lamps[4];
  assign bus.lc = lamps[3];
  assign bus.ra = lamps[2];
  assign bus.rb = lamps[1];
  assign bus.rc = lamps[0];

endmodule

`default_nettype wire

// File: tb/tb_thunderbird_turn_signal.sv
// ============================================================================
// Module   : tb_thunderbird_turn_signal
// Purpose  : Directed-vector scoreboard bench for the turn-signal sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_thunderbird_turn_signal;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  logic [5:0] exp_q[$];

  thunderbird_turn_signal_if bus ();

  thunderbird_turn_signal dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] lamps();
    return {bus.la, bus.lb, bus.lc, bus.ra, bus.rb, bus.rc};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: lamps=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive switches away from the edge and queue the lamps expected after it
  task automatic step(input logic l, input logic r, input logic [5:0] exp);
    @(negedge clk);
    bus.left_sw  = l;
    bus.right_sw = r;
    exp_q.push_back(exp);
  endtask

  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("edge", lamps(), e);
      end
    end
  end

  initial begin : stimulus
    n_vec        = 0;
    n_bad        = 0;
    reset        = 1'b0;
    bus.left_sw  = 1'b0;
    bus.right_sw = 1'b0;
    #12;
    check("reset_state", lamps(), 6'b000000);
    @(negedge clk);
    reset = 1'b1;

    // Idle with no requests
    repeat (3) step(1'b0, 1'b0, 6'b000000);

    // Left held: period-4 sweep
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 6'b100000);
      step(1'b1, 1'b0, 6'b110000);
      step(1'b1, 1'b0, 6'b111000);
      step(1'b1, 1'b0, 6'b000000);
    end
    step(1'b0, 1'b0, 6'b000000);

    // Right held
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 6'b000100);
      step(1'b0, 1'b1, 6'b000110);
      step(1'b0, 1'b1, 6'b000111);
      step(1'b0, 1'b1, 6'b000000);
    end
    step(1'b0, 1'b0, 6'b000000);

    // Hazard flash
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 6'b111111);
      step(1'b1, 1'b1, 6'b000000);
    end
    step(1'b0, 1'b0, 6'b000000);

    // Single-cycle left pulse completes the sweep then rests
    step(1'b1, 1'b0, 6'b100000);
    step(1'b0, 1'b0, 6'b110000);
    step(1'b0, 1'b0, 6'b111000);
    step(1'b0, 1'b0, 6'b000000);
    step(1'b0, 1'b0, 6'b000000);

    // Flip to right during L2
    step(1'b1, 1'b0, 6'b100000);
    step(1'b0, 1'b0, 6'b110000);
    step(1'b0, 1'b1, 6'b111000);
    step(1'b0, 1'b1, 6'b000000);
    step(1'b0, 1'b1, 6'b000100);
    step(1'b0, 1'b1, 6'b000110);

    // Asynchronous reset mid R2, then release with right held
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", lamps(), 6'b000000);
    @(posedge clk);
    #1;
    check("reset_held", lamps(), 6'b000000);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(6'b000100);
    step(1'b0, 1'b1, 6'b000110);
    step(1'b0, 1'b1, 6'b000111);
    step(1'b0, 1'b0, 6'b000000);

    // Both pressed mid-sweep: finish, IDLE, then HAZ
    step(1'b1, 1'b0, 6'b100000);
    step(1'b1, 1'b1, 6'b110000);
    step(1'b1, 1'b1, 6'b111000);
    step(1'b1, 1'b1, 6'b000000);
    step(1'b1, 1'b1, 6'b111111);
    step(1'b0, 1'b0, 6'b000000);

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
